// File: rtl/fmul_pp_round.sv
// fmul_pp_round: back end of the binary32 multiplier. Sums the 13 Booth partial
// products one per cycle, then normalizes, rounds to nearest-even and packs the result.
module fmul_pp_round #(
  parameter int BIAS = 127
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [48:0] P0,
  input  logic [48:0] P1,
  input  logic [48:0] P2,
  input  logic [48:0] P3,
  input  logic [48:0] P4,
  input  logic [48:0] P5,
  input  logic [48:0] P6,
  input  logic [48:0] P7,
  input  logic [48:0] P8,
  input  logic [48:0] P9,
  input  logic [48:0] P10,
  input  logic [48:0] P11,
  input  logic [48:0] P12,
  input  logic        sign,
  input  logic [8:0]  expc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {IDLE, ACC, NORM, DONE} state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic [48:0] w_pIn [13];
  logic [48:0] r_p   [13];
  logic [48:0] w_pSel;

  logic        r_sign;
  logic [8:0]  r_expc;
  logic [48:0] r_acc;
  logic [3:0]  r_cnt;

  logic [31:0] r_result;
  logic        r_ovf;
  logic        r_unf;

  logic        w_top;
  logic [22:0] w_frac;
  logic        w_guard;
  logic        w_sticky;
  logic        w_roundUp;
  logic [23:0] w_fracRnd;
  logic signed [10:0] w_exp;
  logic [31:0] w_packed;
  logic        w_ovf;
  logic        w_unf;

  assign w_pIn[0]  = P0;
  assign w_pIn[1]  = P1;
  assign w_pIn[2]  = P2;
  assign w_pIn[3]  = P3;
  assign w_pIn[4]  = P4;
  assign w_pIn[5]  = P5;
  assign w_pIn[6]  = P6;
  assign w_pIn[7]  = P7;
  assign w_pIn[8]  = P8;
  assign w_pIn[9]  = P9;
  assign w_pIn[10] = P10;
  assign w_pIn[11] = P11;
  assign w_pIn[12] = P12;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_nextState = ACC;
      ACC:     if (r_cnt == 4'd12) w_nextState = NORM;
      NORM:    w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  // Operand bank is only meaningful after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && in_valid) begin
      for (int i = 0; i < 13; i++) begin
        r_p[i] <= w_pIn[i];
      end
    end
  end

  always_comb begin
    w_pSel = '0;
    for (int i = 0; i < 13; i++) begin
      if (r_cnt == 4'(i)) w_pSel = r_p[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign   <= 1'b0;
      r_expc   <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sign <= sign;
            r_expc <= expc;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        ACC: begin
          r_acc <= r_acc + w_pSel;
          r_cnt <= r_cnt + 4'd1;
        end
        NORM: begin
          r_result <= w_packed;
          r_ovf    <= w_ovf;
          r_unf    <= w_unf;
        end
        default: ;
      endcase
    end
  end

  // Bit 48 is always clear for legal inputs; folding it in keeps every acc bit observed.
  always_comb begin
    w_top     = r_acc[48] | r_acc[47];
    w_frac    = '0;
    w_guard   = 1'b0;
    w_sticky  = 1'b0;
    if (w_top) begin
      w_frac   = r_acc[46:24];
      w_guard  = r_acc[23];
      w_sticky = |r_acc[22:0];
    end else begin
      w_frac   = r_acc[45:23];
      w_guard  = r_acc[22];
      w_sticky = |r_acc[21:0];
    end
    w_roundUp = w_guard & (w_sticky | w_frac[0]);
    w_fracRnd = {1'b0, w_frac} + {23'd0, w_roundUp};
    w_exp     = $signed({2'b00, r_expc} - 11'(BIAS) + {10'd0, w_top} + {10'd0, w_fracRnd[23]});
    w_ovf     = 1'b0;
    w_unf     = 1'b0;
    w_packed  = {r_sign, w_exp[7:0], w_fracRnd[22:0]};
    if (w_exp >= 11'sd255) begin
      w_packed = {r_sign, 8'hFF, 23'h0};
      w_ovf    = 1'b1;
    end else if (w_exp <= 11'sd0) begin
      w_packed = {r_sign, 31'h0};
      w_unf    = 1'b1;
    end
  end

  assign result    = r_result;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_fmul_pp_round.sv
// Scoreboard bench for fmul_pp_round: directed operands push expected packed results,
// an independent monitor pops and compares on every output handshake.
module tb_fmul_pp_round;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [48:0] tbP [13];
  logic        sign;
  logic [8:0]  expc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t expQ[$];

  always #5 clk = ~clk;

  fmul_pp_round #(.BIAS(127)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .P0(tbP[0]), .P1(tbP[1]), .P2(tbP[2]), .P3(tbP[3]), .P4(tbP[4]),
    .P5(tbP[5]), .P6(tbP[6]), .P7(tbP[7]), .P8(tbP[8]), .P9(tbP[9]),
    .P10(tbP[10]), .P11(tbP[11]), .P12(tbP[12]),
    .sign(sign), .expc(expc),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    nCompared++;
    if (actual !== required) begin
      nMismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic failNow(input string name);
    nCompared++;
    nMismatched++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  // Monitor: compares whenever the DUT completes an output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        failNow("unexpected_out_valid");
      end else begin
        e = expQ.pop_front();
        checkOutput({e.name, "_result"}, result, e.res);
        checkOutput({e.name, "_flags"}, {30'd0, overflow, underflow}, {30'd0, e.ovf, e.unf});
      end
    end
  end

  task automatic driveOperand(input logic [47:0] m, input logic [48:0] x, input int idx,
                              input logic sgn, input logic [8:0] ex);
    for (int i = 0; i < 13; i++) tbP[i] = '0;
    tbP[0]   = {1'b0, m} + x;
    tbP[idx] = tbP[idx] - x;
    sign = sgn;
    expc = ex;
  endtask

  task automatic waitAccept(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) failNow({name, "_accept_timeout"});
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [47:0] m, input logic [48:0] x, input int idx,
                               input logic sgn, input logic [8:0] ex, input string name,
                               input logic [31:0] res, input logic ovf, input logic unf);
    exp_t e;
    driveOperand(m, x, idx, sgn, ex);
    in_valid = 1'b1;
    waitAccept(name);
    in_valid = 1'b0;
    e.name = name;
    e.res  = res;
    e.ovf  = ovf;
    e.unf  = unf;
    expQ.push_back(e);
  endtask

  task automatic waitOutValid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 40);
    if (!out_valid) failNow("out_valid_timeout");
  endtask

  task automatic runOp(input logic [47:0] m, input logic [48:0] x, input int idx,
                       input logic sgn, input logic [8:0] ex, input string name,
                       input logic [31:0] res, input logic ovf, input logic unf);
    int lat;
    applyStimulus(m, x, idx, sgn, ex, name, res, ovf, unf);
    waitOutValid(lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   lat;
    logic bpOk;
    logic quiet;
    int   n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sign      = 1'b0;
    expc      = '0;
    for (int i = 0; i < 13; i++) tbP[i] = '0;

    #12;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_flags", {30'd0, overflow, underflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1.5 x 2.0 with latency and single-cycle out_valid checks
    applyStimulus(48'h600000000000, 49'd0, 1, 1'b0, 9'd255, "mul_1p5x2", 32'h40400000, 1'b0, 1'b0);
    waitOutValid(lat);
    checkOutput("latency", 32'(lat), 32'd14);
    @(posedge clk);
    @(negedge clk);
    checkOutput("pulse_width", {31'd0, out_valid}, 32'd0);
    checkOutput("in_ready_after_done", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    runOp(48'h900000000000, 49'h123456789AB, 5, 1'b0, 9'd254, "wrap_1p5x1p5", 32'h40100000, 1'b0, 1'b0);
    runOp(48'h600000000000, 49'h0ABCDEF01234, 12, 1'b0, 9'd255, "split_p12", 32'h40400000, 1'b0, 1'b0);
    runOp(48'h400000400000, 49'd0, 1, 1'b0, 9'd254, "tie_even", 32'h3F800000, 1'b0, 1'b0);
    runOp(48'h400000C00000, 49'd0, 1, 1'b0, 9'd254, "tie_odd", 32'h3F800002, 1'b0, 1'b0);
    runOp(48'h7FFFFFC00000, 49'd0, 1, 1'b0, 9'd254, "round_carry", 32'h40000000, 1'b0, 1'b0);
    runOp(48'h400000000000, 49'd0, 1, 1'b1, 9'd400, "overflow", 32'hFF800000, 1'b1, 1'b0);
    runOp(48'h400000000000, 49'd0, 1, 1'b1, 9'd100, "underflow", 32'h80000000, 1'b0, 1'b1);
    runOp(48'hFFFFFF000000, 49'd0, 1, 1'b1, 9'd381, "round_overflow", 32'hFF800000, 1'b1, 1'b0);
    runOp(48'h800000000000, 49'd0, 1, 1'b1, 9'd380, "max_normal", 32'hFF000000, 1'b0, 1'b0);
    runOp(48'h400000000000, 49'd0, 1, 1'b0, 9'd128, "min_normal", 32'h00800000, 1'b0, 1'b0);
    runOp(48'h400000000000, 49'd0, 1, 1'b0, 9'd127, "exp_zero", 32'h00000000, 1'b0, 1'b1);

    // Backpressure: result must hold while a competing operand is offered
    out_ready = 1'b0;
    applyStimulus(48'h900000000000, 49'd0, 1, 1'b0, 9'd254, "bp_op", 32'h40100000, 1'b0, 1'b0);
    waitOutValid(lat);
    driveOperand(48'h400000C00000, 49'd0, 1, 1'b0, 9'd254);
    in_valid = 1'b1;
    bpOk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (result !== 32'h40100000 || in_ready !== 1'b0 || out_valid !== 1'b1) bpOk = 1'b0;
    end
    checkOutput("bp_hold", {31'd0, bpOk}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_release_idle", {31'd0, in_ready}, 32'd1);
    begin
      exp_t e;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      e.name = "bp_next";
      e.res  = 32'h3F800002;
      e.ovf  = 1'b0;
      e.unf  = 1'b0;
      expQ.push_back(e);
    end
    @(negedge clk);
    checkOutput("bp_next_accept", {31'd0, in_ready}, 32'd0);
    waitOutValid(lat);
    @(posedge clk);
    #1;

    // Reset in the middle of accumulation
    driveOperand(48'h600000000000, 49'd0, 1, 1'b0, 9'd255);
    in_valid = 1'b1;
    waitAccept("rst_op");
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) quiet = 1'b0;
    end
    checkOutput("rst_no_output", {31'd0, quiet}, 32'd1);
    @(posedge clk);
    #1;
    runOp(48'h600000000000, 49'd0, 1, 1'b0, 9'd255, "after_reset", 32'h40400000, 1'b0, 1'b0);

    n = 0;
    while (expQ.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (expQ.size() > 0) failNow("scoreboard_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
